// File: rtl/aliens_matrix.sv
// aliens_matrix: 6x14 alien formation state with combinational cell queries, a hit-to-kill
// path, a single explosion slot and kill scoring. Optional build macro: ALIENS_ARMORED_EN.
module aliens_matrix #(
    parameter int COLS           = 14,
    parameter int ROWS           = 6,
    parameter int CELL_SHIFT     = 5,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               newLevel,
    input  logic [3:0]         colIdx,
    input  logic [2:0]         rowIdx,
    output logic [1:0]         alien_data,
    input  logic [3:0]         drawCol,
    input  logic [2:0]         drawRow,
    output logic [1:0]         drawData,
    input  logic               alienHit,
    input  logic signed [10:0] hitX,
    input  logic signed [10:0] hitY,
    input  logic signed [10:0] aliensTLX,
    input  logic signed [10:0] aliensTLY,
    output logic               scorePulse,
    output logic [5:0]         scoreValue,
    output logic [6:0]         aliveCount,
    output logic               allDead
);

    localparam int CNT_W = $clog2(EXPLODE_FRAMES + 1);

`ifdef ALIENS_ARMORED_EN
    localparam bit ARMORED = 1'b1;
`else
    localparam bit ARMORED = 1'b0;
`endif

    typedef enum logic [1:0] {
        CELL_EMPTY     = 2'b00,
        CELL_EXPLODING = 2'b01,
        CELL_ALIVE     = 2'b10,
        CELL_ARMORED   = 2'b11
    } cell_t;

    cell_t             cells_q [ROWS][COLS];
    cell_t             cells_d [ROWS][COLS];
    logic [6:0]        alive_count_q, alive_count_d;
    logic [3:0]        slot_col_q, slot_col_d;
    logic [2:0]        slot_row_q, slot_row_d;
    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic              hit_taken_q, hit_taken_d;
    logic              score_pulse_q, score_pulse_d;
    logic [5:0]        score_value_q, score_value_d;

    logic signed [11:0] dx, dy, dcol, drow;
    logic               hit_in_range;
    logic [3:0]         hit_col;
    logic [2:0]         hit_row;
    cell_t              hit_cell;
    logic               hit_ok;

    function automatic cell_t init_cell(input int unsigned row);
        return (ARMORED && row < 2) ? CELL_ARMORED : CELL_ALIVE;
    endfunction

    function automatic logic [5:0] kill_points(input logic [2:0] row);
        if (row < 3'd2)      return 6'd30;
        else if (row < 3'd4) return 6'd20;
        else                 return 6'd10;
    endfunction

    assign alien_data = (colIdx < 4'(COLS) && rowIdx < 3'(ROWS)) ? cells_q[rowIdx][colIdx] : 2'b00;
    assign drawData   = (drawCol < 4'(COLS) && drawRow < 3'(ROWS)) ? cells_q[drawRow][drawCol] : 2'b00;

    // Sign-extend to 12 bits so a formation near the screen edge cannot wrap into a valid cell
    assign dx   = {hitX[10], hitX} - {aliensTLX[10], aliensTLX};
    assign dy   = {hitY[10], hitY} - {aliensTLY[10], aliensTLY};
    assign dcol = dx >>> CELL_SHIFT;
    assign drow = dy >>> CELL_SHIFT;

    assign hit_in_range = !dcol[11] && !drow[11] &&
                          (dcol[10:0] < 11'(COLS)) && (drow[10:0] < 11'(ROWS));
    assign hit_col  = dcol[3:0];
    assign hit_row  = drow[2:0];
    assign hit_cell = hit_in_range ? cells_q[hit_row][hit_col] : CELL_EMPTY;
    assign hit_ok   = alienHit && !hit_taken_q && hit_cell[1];

    always_comb begin
        cells_d       = cells_q;
        alive_count_d = alive_count_q;
        slot_col_d    = slot_col_q;
        slot_row_d    = slot_row_q;
        slot_cnt_d    = slot_cnt_q;
        hit_taken_d   = hit_taken_q;
        score_pulse_d = 1'b0;
        score_value_d = score_value_q;

        if (newLevel) begin
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++)
                    cells_d[r][c] = init_cell(r);
            alive_count_d = 7'(ROWS * COLS);
            slot_cnt_d    = '0;
            hit_taken_d   = 1'b0;
        end else begin
            if (startOfFrame) begin
                hit_taken_d = 1'b0;
                if (slot_cnt_q != '0) begin
                    slot_cnt_d = slot_cnt_q - CNT_W'(1);
                    if (slot_cnt_q == CNT_W'(1))
                        cells_d[slot_row_q][slot_col_q] = CELL_EMPTY;
                end
            end

            // A kill overrides the slot bookkeeping above but still retires the old slot cell
            if (hit_ok) begin
                hit_taken_d = 1'b1;
`ifdef ALIENS_ARMORED_EN
                if (hit_cell == CELL_ARMORED)
                    cells_d[hit_row][hit_col] = CELL_ALIVE;
`endif
                if (hit_cell == CELL_ALIVE) begin
                    if (slot_cnt_q != '0)
                        cells_d[slot_row_q][slot_col_q] = CELL_EMPTY;
                    cells_d[hit_row][hit_col] = CELL_EXPLODING;
                    slot_col_d    = hit_col;
                    slot_row_d    = hit_row;
                    slot_cnt_d    = CNT_W'(EXPLODE_FRAMES);
                    alive_count_d = alive_count_q - 7'd1;
                    score_pulse_d = 1'b1;
                    score_value_d = kill_points(hit_row);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++)
                    cells_q[r][c] <= init_cell(r);
            alive_count_q <= 7'(ROWS * COLS);
            slot_col_q    <= '0;
            slot_row_q    <= '0;
            slot_cnt_q    <= '0;
            hit_taken_q   <= 1'b0;
            score_pulse_q <= 1'b0;
            score_value_q <= '0;
        end else begin
            cells_q       <= cells_d;
            alive_count_q <= alive_count_d;
            slot_col_q    <= slot_col_d;
            slot_row_q    <= slot_row_d;
            slot_cnt_q    <= slot_cnt_d;
            hit_taken_q   <= hit_taken_d;
            score_pulse_q <= score_pulse_d;
            score_value_q <= score_value_d;
        end
    end

    assign scorePulse = score_pulse_q;
    assign scoreValue = score_value_q;
    assign aliveCount = alive_count_q;
    assign allDead    = (alive_count_q == '0);

endmodule

// File: tb/tb_aliens_matrix.sv
// Directed self-checking bench for aliens_matrix; formation top-left fixed at (100,50).
module tb_aliens_matrix;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic               newLevel;
    logic [3:0]         colIdx;
    logic [2:0]         rowIdx;
    logic [1:0]         alien_data;
    logic [3:0]         drawCol;
    logic [2:0]         drawRow;
    logic [1:0]         drawData;
    logic               alienHit;
    logic signed [10:0] hitX, hitY, aliensTLX, aliensTLY;
    logic               scorePulse;
    logic [5:0]         scoreValue;
    logic [6:0]         aliveCount;
    logic               allDead;

    int total;
    int bad;
    bit alive_m [6][14];
    int exp_alive;

`ifdef ALIENS_ARMORED_EN
    localparam bit ARM = 1'b1;
`else
    localparam bit ARM = 1'b0;
`endif

    aliens_matrix dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newLevel(newLevel),
        .colIdx(colIdx), .rowIdx(rowIdx), .alien_data(alien_data),
        .drawCol(drawCol), .drawRow(drawRow), .drawData(drawData),
        .alienHit(alienHit), .hitX(hitX), .hitY(hitY),
        .aliensTLX(aliensTLX), .aliensTLY(aliensTLY),
        .scorePulse(scorePulse), .scoreValue(scoreValue),
        .aliveCount(aliveCount), .allDead(allDead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] init_exp(input int r);
        return (ARM && r < 2) ? 2'b11 : 2'b10;
    endfunction

    task automatic peek(input int c, input int r, output logic [1:0] v);
        colIdx = 4'(c);
        rowIdx = 3'(r);
        #1;
        v = alien_data;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic aim(input int c, input int r);
        hitX = 11'(100 + 32 * c + 5);
        hitY = 11'(50 + 32 * r + 5);
    endtask

    task automatic hit_cycle(input int c, input int r);
        aim(c, r);
        alienHit = 1'b1;
        @(negedge clk);
        alienHit = 1'b0;
    endtask

    task automatic kill_cell(input int c, input int r);
        sof();
        if (ARM && r < 2) begin
            hit_cycle(c, r);
            sof();
        end
        hit_cycle(c, r);
        alive_m[r][c] = 1'b0;
        exp_alive--;
    endtask

    task automatic test_reset();
        logic [1:0] v;
        resetN = 1'b0; startOfFrame = 1'b0; newLevel = 1'b0; alienHit = 1'b0;
        hitX = '0; hitY = '0; aliensTLX = 11'sd100; aliensTLY = 11'sd50;
        colIdx = '0; rowIdx = '0; drawCol = '0; drawRow = '0;
        #12;
        peek(13, 5, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL reset_c13r5 got=%b exp=10", v); end
        peek(14, 5, v);
        total++; if (v !== 2'b00) begin bad++; $display("FAIL reset_c14 got=%b exp=00", v); end
        peek(0, 6, v);
        total++; if (v !== 2'b00) begin bad++; $display("FAIL reset_r6 got=%b exp=00", v); end
        drawCol = 4'd0; drawRow = 3'd0; #1;
        total++; if (drawData !== init_exp(0)) begin bad++; $display("FAIL reset_draw00 got=%b exp=%b", drawData, init_exp(0)); end
        total++; if (aliveCount !== 7'd84) begin bad++; $display("FAIL reset_alive got=%0d exp=84", aliveCount); end
        total++; if (allDead !== 1'b0) begin bad++; $display("FAIL reset_alldead got=%b exp=0", allDead); end
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", scorePulse); end
        total++; if (scoreValue !== 6'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", scoreValue); end
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_kill();
        logic [1:0] v;
        int pulses;
        sof();
        hitX = 11'sd170; hitY = 11'sd210; alienHit = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (scorePulse === 1'b1) pulses++;
        end
        alienHit = 1'b0;
        alive_m[5][2] = 1'b0; exp_alive--;
        total++; if (pulses != 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
        peek(2, 5, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL single_cell got=%b exp=01", v); end
        total++; if (aliveCount !== 7'd83) begin bad++; $display("FAIL single_alive got=%0d exp=83", aliveCount); end
        total++; if (scoreValue !== 6'd10) begin bad++; $display("FAIL single_score got=%0d exp=10", scoreValue); end
        repeat (7) sof();
        peek(2, 5, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL single_sof7 got=%b exp=01", v); end
        sof();
        peek(2, 5, v);
        total++; if (v !== 2'b00) begin bad++; $display("FAIL single_sof8 got=%b exp=00", v); end
    endtask

    task automatic test_slot_replace();
        logic [1:0] v;
        kill_cell(0, 0);
        total++; if (scorePulse !== 1'b1) begin bad++; $display("FAIL slot_pulse0 got=%b exp=1", scorePulse); end
        total++; if (scoreValue !== 6'd30) begin bad++; $display("FAIL slot_score0 got=%0d exp=30", scoreValue); end
        peek(0, 0, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL slot_cell00 got=%b exp=01", v); end
        kill_cell(1, 0);
        total++; if (scoreValue !== 6'd30) begin bad++; $display("FAIL slot_score1 got=%0d exp=30", scoreValue); end
        peek(0, 0, v);
        total++; if (v !== 2'b00) begin bad++; $display("FAIL slot_old_cleared got=%b exp=00", v); end
        peek(1, 0, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL slot_new got=%b exp=01", v); end
        total++; if (aliveCount !== 7'(exp_alive)) begin bad++; $display("FAIL slot_alive got=%0d exp=%0d", aliveCount, exp_alive); end
        repeat (7) sof();
        peek(1, 0, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL slot_fresh7 got=%b exp=01", v); end
        sof();
        peek(1, 0, v);
        total++; if (v !== 2'b00) begin bad++; $display("FAIL slot_fresh8 got=%b exp=00", v); end
    endtask

    task automatic test_ignored();
        logic [1:0] v;
        sof();
        hitX = 11'sd99; hitY = 11'sd119; alienHit = 1'b1;
        @(negedge clk);
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL ign_negdx_pulse got=%b exp=0", scorePulse); end
        hitX = 11'sd105; hitY = 11'sd247;
        @(negedge clk);
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL ign_row6_pulse got=%b exp=0", scorePulse); end
        hitX = 11'sd553; hitY = 11'sd119;
        @(negedge clk);
        alienHit = 1'b0;
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL ign_col14_pulse got=%b exp=0", scorePulse); end
        total++; if (aliveCount !== 7'(exp_alive)) begin bad++; $display("FAIL ign_alive got=%0d exp=%0d", aliveCount, exp_alive); end
        total++; if (scoreValue !== 6'd30) begin bad++; $display("FAIL ign_score_held got=%0d exp=30", scoreValue); end
        hit_cycle(4, 2);
        alive_m[2][4] = 1'b0; exp_alive--;
        total++; if (scorePulse !== 1'b1) begin bad++; $display("FAIL ign_then_kill_pulse got=%b exp=1", scorePulse); end
        total++; if (scoreValue !== 6'd20) begin bad++; $display("FAIL ign_then_kill_score got=%0d exp=20", scoreValue); end
        peek(4, 2, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL ign_then_kill_cell got=%b exp=01", v); end
    endtask

    task automatic test_one_per_frame();
        logic [1:0] v;
        sof();
        hit_cycle(5, 3);
        alive_m[3][5] = 1'b0; exp_alive--;
        total++; if (scorePulse !== 1'b1) begin bad++; $display("FAIL opf_first_pulse got=%b exp=1", scorePulse); end
        hit_cycle(6, 3);
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL opf_second_pulse got=%b exp=0", scorePulse); end
        peek(6, 3, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL opf_second_cell got=%b exp=10", v); end
        startOfFrame = 1'b1; aim(6, 3); alienHit = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0; alienHit = 1'b0;
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL opf_sof_taken_pulse got=%b exp=0", scorePulse); end
        peek(6, 3, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL opf_sof_taken_cell got=%b exp=10", v); end
        hit_cycle(6, 3);
        alive_m[3][6] = 1'b0; exp_alive--;
        total++; if (scorePulse !== 1'b1) begin bad++; $display("FAIL opf_after_clear_pulse got=%b exp=1", scorePulse); end
        peek(6, 3, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL opf_after_clear_cell got=%b exp=01", v); end
        peek(5, 3, v);
        total++; if (v !== 2'b00) begin bad++; $display("FAIL opf_old_slot got=%b exp=00", v); end
        sof();
        startOfFrame = 1'b1; aim(7, 3); alienHit = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0; alienHit = 1'b0;
        alive_m[3][7] = 1'b0; exp_alive--;
        total++; if (scorePulse !== 1'b1) begin bad++; $display("FAIL opf_sof_clear_pulse got=%b exp=1", scorePulse); end
        hit_cycle(8, 3);
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL opf_taken_again_pulse got=%b exp=0", scorePulse); end
        peek(8, 3, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL opf_taken_again_cell got=%b exp=10", v); end
        total++; if (aliveCount !== 7'(exp_alive)) begin bad++; $display("FAIL opf_alive got=%0d exp=%0d", aliveCount, exp_alive); end
    endtask

`ifdef ALIENS_ARMORED_EN
    task automatic test_armored();
        logic [1:0] v;
        sof();
        hit_cycle(5, 1);
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL arm_first_pulse got=%b exp=0", scorePulse); end
        peek(5, 1, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL arm_first_cell got=%b exp=10", v); end
        total++; if (aliveCount !== 7'(exp_alive)) begin bad++; $display("FAIL arm_first_alive got=%0d exp=%0d", aliveCount, exp_alive); end
        hit_cycle(5, 1);
        peek(5, 1, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL arm_same_frame_cell got=%b exp=10", v); end
        sof();
        hit_cycle(5, 1);
        alive_m[1][5] = 1'b0; exp_alive--;
        total++; if (scorePulse !== 1'b1) begin bad++; $display("FAIL arm_kill_pulse got=%b exp=1", scorePulse); end
        total++; if (scoreValue !== 6'd30) begin bad++; $display("FAIL arm_kill_score got=%0d exp=30", scoreValue); end
        peek(5, 1, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL arm_kill_cell got=%b exp=01", v); end
    endtask
`endif

    task automatic test_kill_all_new_level();
        logic [1:0] v;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 14; c++) begin
                if (alive_m[r][c]) begin
                    if (exp_alive == 1) begin
                        total++; if (allDead !== 1'b0) begin bad++; $display("FAIL all_before_last got=%b exp=0", allDead); end
                    end
                    kill_cell(c, r);
                    total++; if (scorePulse !== 1'b1) begin bad++; $display("FAIL all_pulse c=%0d r=%0d got=%b exp=1", c, r, scorePulse); end
                    total++; if (aliveCount !== 7'(exp_alive)) begin bad++; $display("FAIL all_alive c=%0d r=%0d got=%0d exp=%0d", c, r, aliveCount, exp_alive); end
                end
            end
        end
        total++; if (allDead !== 1'b1) begin bad++; $display("FAIL all_dead got=%b exp=1", allDead); end
        newLevel = 1'b1;
        @(negedge clk);
        newLevel = 1'b0;
        exp_alive = 84;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 14; c++) alive_m[r][c] = 1'b1;
        total++; if (aliveCount !== 7'd84) begin bad++; $display("FAIL nl_alive got=%0d exp=84", aliveCount); end
        total++; if (allDead !== 1'b0) begin bad++; $display("FAIL nl_alldead got=%b exp=0", allDead); end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 14; c++) begin
                drawCol = 4'(c); drawRow = 3'(r); #0.1;
                total++; if (drawData !== init_exp(r)) begin bad++; $display("FAIL nl_cell c=%0d r=%0d got=%b exp=%b", c, r, drawData, init_exp(r)); end
            end
        end
        repeat (8) sof();
        peek(13, 5, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL nl_slot_freed got=%b exp=10", v); end
        sof();
        newLevel = 1'b1; aim(3, 4); alienHit = 1'b1;
        @(negedge clk);
        newLevel = 1'b0; alienHit = 1'b0;
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL nl_hit_pulse got=%b exp=0", scorePulse); end
        total++; if (aliveCount !== 7'd84) begin bad++; $display("FAIL nl_hit_alive got=%0d exp=84", aliveCount); end
        peek(3, 4, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL nl_hit_cell got=%b exp=10", v); end
    endtask

    task automatic test_async_reset();
        logic [1:0] v;
        kill_cell(3, 4);
        total++; if (scorePulse !== 1'b1) begin bad++; $display("FAIL ar_pulse_before got=%b exp=1", scorePulse); end
        peek(3, 4, v);
        total++; if (v !== 2'b01) begin bad++; $display("FAIL ar_cell_before got=%b exp=01", v); end
        resetN = 1'b0;
        #1;
        total++; if (scorePulse !== 1'b0) begin bad++; $display("FAIL ar_pulse got=%b exp=0", scorePulse); end
        total++; if (scoreValue !== 6'd0) begin bad++; $display("FAIL ar_score got=%0d exp=0", scoreValue); end
        total++; if (aliveCount !== 7'd84) begin bad++; $display("FAIL ar_alive got=%0d exp=84", aliveCount); end
        peek(3, 4, v);
        total++; if (v !== 2'b10) begin bad++; $display("FAIL ar_cell got=%b exp=10", v); end
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_alive = 84;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 14; c++) alive_m[r][c] = 1'b1;
        test_reset();
        test_single_kill();
        test_slot_replace();
        test_ignored();
        test_one_per_frame();
`ifdef ALIENS_ARMORED_EN
        test_armored();
`endif
        test_kill_all_new_level();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aliens_matrix.md
# aliens_matrix

Responder side of the alien-fire scan and the hit-kill path: holds the 6×14 alien formation state and answers combinational `(colIdx,rowIdx)` queries from the rocket controller with `alien_data`. Turns player-rocket collision pulses into cell kills, with a single-slot explosion animation and a kill score. Sits between the collision detector, the rocket controller, the alien drawer and the score keeper.

## Interface
- COLS, 14, formation columns (indices 0..13)
- ROWS, 6, formation rows (indices 0..5, row 5 is the bottom row)
- CELL_SHIFT, 5, log2 of the cell size in pixels (32)
- EXPLODE_FRAMES, 8, frames a killed cell stays in the exploding state

- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-clock pulse per frame
- newLevel  in  1  one-clock pulse; reloads the full formation
- colIdx  in  4  query column (from rocket controller)
- rowIdx  in  3  query row (from rocket controller)
- alien_data  out  2  state of cell (colIdx,rowIdx); combinational
- drawCol  in  4  drawer query column
- drawRow  in  3  drawer query row
- drawData  out  2  state of cell (drawCol,drawRow); combinational
- alienHit  in  1  player rocket overlaps an alien pixel (may stay high for many clocks)
- hitX, hitY  in  11 each, signed  pixel coordinates of the collision
- aliensTLX, aliensTLY  in  11 each, signed  formation top-left
- scorePulse  out  1  one-clock pulse on a kill
- scoreValue  out  6  points of the last kill; held until the next kill
- aliveCount  out  7  number of cells with bit1 set
- allDead  out  1  high while aliveCount == 0

## Operation
- Cell encoding: 00 empty, 01 exploding, 10 alive, 11 alive-armored. bit1 = shootable/hittable.
- Out-of-range query (colIdx ≥ 14 or rowIdx ≥ 6): alien_data/drawData = 00.
- Hit address: dx = hitX − aliensTLX, dy = hitY − aliensTLY in 12-bit signed; col = dx>>>5, row = dy>>>5. A negative dx/dy or col/row out of range means the hit is ignored.
- Hit acceptance: alienHit high, hitTaken flag clear, and addressed cell bit1 = 1. Acceptance sets hitTaken. Further hits are ignored until the next startOfFrame.
- Accepted hit on 11: cell becomes 10. No score.
- Accepted hit on 10: cell becomes 01 and is loaded into the explosion slot (slotCol, slotRow, slotCnt = EXPLODE_FRAMES). aliveCount decrements. scorePulse fires.
  - scoreValue: rows 0–1 give 30, rows 2–3 give 20, rows 4–5 give 10.
- Explosion slot: decrements on each startOfFrame. At 0 the slot cell becomes 00 and the slot frees.
  - A new kill while the slot is busy immediately writes 00 to the old slot cell, then reloads the slot.
- newLevel: all cells reload to the initial pattern, aliveCount = 84, the slot frees, hitTaken clears, and scorePulse is suppressed.
- Priority within a cycle: newLevel > accepted hit > slot expiry.
  - A hit and startOfFrame in the same cycle: the hit is evaluated against the old hitTaken and is accepted if the flag was clear. After the cycle, hitTaken = 1 if the hit was accepted, else 0.
  - If the slot expires in the same cycle as a kill, the old cell still becomes 00.

## Timing
- Reset values: all cells hold the initial pattern, aliveCount = 84, allDead = 0, scorePulse = 0, scoreValue = 0, slot free, hitTaken = 0.
  - alien_data/drawData reflect the reset pattern immediately.
- alien_data and drawData are combinational from the cell registers with zero latency. The controller advances its scan one cell per clock.
- Accepted hit sampled at edge T: the cell update, aliveCount, allDead and scorePulse are all visible after T.
  - scorePulse is high for exactly the cycle T..T+1.
- Explosion lasts EXPLODE_FRAMES startOfFrame pulses after the kill edge. The cell reads 01 throughout.
- Reset asserted mid-explosion or mid-hit returns to the reset values asynchronously.

## Configuration
- ALIENS_ARMORED_EN defined: rows 0 and 1 load as 11 at reset and on newLevel. Each of those cells needs two accepted hits, in different frames, to kill.
- ALIENS_ARMORED_EN undefined: every cell loads as 10. Code 11 never occurs and the armored-downgrade path is not compiled.

## Test plan
- Reset, then query col 13/row 5 → alien_data = 10; query col 14 → 00; aliveCount = 84, allDead = 0.
- Formation at TL (100,50), alienHit held 20 clocks at (170,210) → one kill at col 2/row 5: cell 01, aliveCount 83, single scorePulse, scoreValue 10. After 8 startOfFrame pulses the cell reads 00.
- Kill (0,0), then in the next frame kill (1,0) → (0,0) becomes 00 immediately, (1,0) becomes 01 with a fresh 8-frame count; scoreValue 30 each time.
- Hit at (99,50) (dx = −1) or at row 6 → ignored: no state change, no pulse.
- Kill all 84 cells one per frame → allDead rises after the last kill edge. Then newLevel → aliveCount 84, allDead 0, all cells 10, or 11 in rows 0–1 when ALIENS_ARMORED_EN is defined.
- With ALIENS_ARMORED_EN, hit (5,1) in frame N → reads 10, no score. Hit again in frame N+1 → reads 01, scoreValue 30. A second hit pulse within frame N is ignored.
